otp_keystream_gen: RTL

- Upstream key source for the one-time-pad XOR stage. It generates N-bit key words from a seeded Galois LFSR and hands them over on a valid/ready handshake.
- It counts issued words and stops permanently after MAX_WORDS, so no key material is reused without an explicit re-seed.
- The key output connects directly to the key input of the pad stage.

---
 rtl/otp_keystream_gen.sv | 111 +++++++++++
 1 files changed

// File: rtl/otp_keystream_gen.sv
// Galois-LFSR key word source with a valid/ready handshake and a per-seed word budget.
// Optional seed-reuse guard: define OTP_SEED_REUSE_GUARD_EN to add last_seed tracking and seed_err.
module otp_keystream_gen #(
    parameter int                N         = 2,
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] TAPS      = 16'hB400,
    parameter int                MAX_WORDS = 1024,
    parameter int                CNT_W     = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              key_ready,
    output logic              key_valid,
    output logic [N-1:0]      key,
    output logic [CNT_W-1:0]  words_used,
    output logic              exhausted,
    output logic              busy
`ifdef OTP_SEED_REUSE_GUARD_EN
    ,
    output logic              seed_err
`endif
);
    localparam int FW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {st_idle, st_fill, st_valid, st_exh} state_t;

    state_t            state, state_d;
    logic [LFSR_W-1:0] lfsr, eff_seed, lfsr_step;
    logic [FW-1:0]     fill_cnt;
    logic [N-1:0]      key_nx;
    logic              load_ok, hs, last_fill;

    // An all-zero state would lock the LFSR, so a zero seed is promoted to 1.
    assign eff_seed  = (seed == '0) ? LFSR_W'(1) : seed;
    assign lfsr_step = (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);
    assign last_fill = (fill_cnt == FW'(N - 1));
    assign hs        = (state == st_valid) && key_ready;

    generate
        if (N == 1) begin : g_key1
            assign key_nx = lfsr[0];
        end else begin : g_keyn
            assign key_nx = {key[N-2:0], lfsr[0]};
        end
    endgenerate

`ifdef OTP_SEED_REUSE_GUARD_EN
    logic [LFSR_W-1:0] last_seed;
    logic              reject;

    // Reloading the same seed after it has produced words would replay key material.
    assign reject  = seed_load && (eff_seed == last_seed) && (words_used != '0);
    assign load_ok = seed_load && !reject;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_seed <= '0;
            seed_err  <= 1'b0;
        end else begin
            seed_err <= reject;
            if (load_ok) last_seed <= eff_seed;
        end
    end
`else
    assign load_ok = seed_load;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= st_idle;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            st_fill:  if (last_fill) state_d = st_valid;
            st_valid: if (key_ready)
                          state_d = (words_used == CNT_W'(MAX_WORDS - 1)) ? st_exh : st_fill;
            default:  ;
        endcase
        // A load overrides any same-cycle handshake; that word is dropped uncounted.
        if (load_ok) state_d = st_fill;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr       <= '0;
            key        <= '0;
            fill_cnt   <= '0;
            words_used <= '0;
        end else if (load_ok) begin
            lfsr       <= eff_seed;
            fill_cnt   <= '0;
            words_used <= '0;
        end else begin
            if (state == st_fill) begin
                lfsr     <= lfsr_step;
                key      <= key_nx;
                fill_cnt <= last_fill ? '0 : fill_cnt + FW'(1);
            end
            if (hs && (words_used != CNT_W'(MAX_WORDS)))
                words_used <= words_used + CNT_W'(1);
        end
    end

    assign key_valid = (state == st_valid);
    assign busy      = (state == st_fill);
    assign exhausted = (state == st_exh);
endmodule
